// File: rtl/execute_cycle.sv
// Execute stage of the RV32I pipeline: operand forwarding, ALU, branch resolution
// and the EX/MEM pipeline register feeding the memory stage.
module execute_cycle #(
    parameter int XLEN      = 32,
    parameter int REGADDR_W = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RegWriteE,
    input  logic                 ALUSrcE,
    input  logic                 MemWriteE,
    input  logic                 ResultSrcE,
    input  logic                 BranchE,
    input  logic [2:0]           ALUControlE,
    input  logic [XLEN-1:0]      RD1_E,
    input  logic [XLEN-1:0]      RD2_E,
    input  logic [XLEN-1:0]      Imm_Ext_E,
    input  logic [REGADDR_W-1:0] RD_E,
    input  logic [XLEN-1:0]      PCE,
    input  logic [XLEN-1:0]      PCPlus4E,
    input  logic [XLEN-1:0]      ResultW,
    input  logic [1:0]           ForwardA_E,
    input  logic [1:0]           ForwardB_E,
    output logic                 PCSrcE,
    output logic [XLEN-1:0]      PCTargetE,
    output logic                 RegWriteM,
    output logic                 MemWriteM,
    output logic                 ResultSrcM,
    output logic [REGADDR_W-1:0] RD_M,
    output logic [XLEN-1:0]      ALUResultM,
    output logic [XLEN-1:0]      WriteDataM,
    output logic [XLEN-1:0]      PCPlus4M
);

    logic [XLEN-1:0] src_a_e;
    logic [XLEN-1:0] write_data_e;
    logic [XLEN-1:0] src_b_e;
    logic [XLEN-1:0] alu_result_e;
    logic            zero_e;

    function automatic logic [XLEN-1:0] fwd_sel(
        input logic [1:0]      sel,
        input logic [XLEN-1:0] reg_val,
        input logic [XLEN-1:0] wb_val,
        input logic [XLEN-1:0] mem_val
    );
        case (sel)
            2'b01:   return wb_val;
            2'b10:   return mem_val;
            default: return reg_val;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] alu(
        input logic [2:0]      op,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic signed [XLEN-1:0] a_s;
        logic signed [XLEN-1:0] b_s;
        a_s = a;
        b_s = b;
        case (op)
            3'b000:  return a + b;
            3'b001:  return a - b;
            3'b010:  return a & b;
            3'b011:  return a | b;
            3'b100:  return a ^ b;
            3'b101:  return {{(XLEN-1){1'b0}}, (a_s < b_s)};
            3'b110:  return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    // EX: operand select (ALUResultM feedback is registered, so no comb loop), ALU, branch
    always_comb begin
        src_a_e      = fwd_sel(ForwardA_E, RD1_E, ResultW, ALUResultM);
        write_data_e = fwd_sel(ForwardB_E, RD2_E, ResultW, ALUResultM);
        src_b_e      = ALUSrcE ? Imm_Ext_E : write_data_e;
        alu_result_e = alu(ALUControlE, src_a_e, src_b_e);
        zero_e       = (alu_result_e == '0);
    end

    assign PCTargetE = PCE + Imm_Ext_E;
    assign PCSrcE    = BranchE & zero_e;

    // EX/MEM boundary
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            RegWriteM  <= 1'b0;
            MemWriteM  <= 1'b0;
            ResultSrcM <= 1'b0;
            RD_M       <= '0;
            ALUResultM <= '0;
            WriteDataM <= '0;
            PCPlus4M   <= '0;
        end else begin
            RegWriteM  <= RegWriteE;
            MemWriteM  <= MemWriteE;
            ResultSrcM <= ResultSrcE;
            RD_M       <= RD_E;
            ALUResultM <= alu_result_e;
            WriteDataM <= write_data_e;
            PCPlus4M   <= PCPlus4E;
        end
    end

endmodule

// File: tb/tb_execute_cycle.sv
// Randomized and directed bench for execute_cycle against a behavioural model.
module tb_execute_cycle;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE;
    logic [2:0]  ALUControlE;
    logic [31:0] RD1_E, RD2_E, Imm_Ext_E, PCE, PCPlus4E, ResultW;
    logic [4:0]  RD_E;
    logic [1:0]  ForwardA_E, ForwardB_E;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        RegWriteM, MemWriteM, ResultSrcM;
    logic [4:0]  RD_M;
    logic [31:0] ALUResultM, WriteDataM, PCPlus4M;

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] m_alu_prev = 0;   // model's view of the previous registered ALU result

    execute_cycle #(.XLEN(32), .REGADDR_W(5)) dut (
        .clk(clk), .rst(rst),
        .RegWriteE(RegWriteE), .ALUSrcE(ALUSrcE), .MemWriteE(MemWriteE),
        .ResultSrcE(ResultSrcE), .BranchE(BranchE), .ALUControlE(ALUControlE),
        .RD1_E(RD1_E), .RD2_E(RD2_E), .Imm_Ext_E(Imm_Ext_E), .RD_E(RD_E),
        .PCE(PCE), .PCPlus4E(PCPlus4E), .ResultW(ResultW),
        .ForwardA_E(ForwardA_E), .ForwardB_E(ForwardB_E),
        .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .RegWriteM(RegWriteM), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .RD_M(RD_M), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick(input logic [1:0] sel, input logic [31:0] rf);
        if (sel == 2'd1) return ResultW;
        if (sel == 2'd2) return m_alu_prev;
        return rf;
    endfunction

    function automatic logic [31:0] ref_alu(input logic [2:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return a ^ b;
            3'd5: return (sa < sb) ? 32'd1 : 32'd0;
            3'd6: return a << (b % 32);
            default: return a >> (b % 32);
        endcase
    endfunction

    // Called just after an active edge: checks combinational outputs, clocks once,
    // then checks every M output against the model.
    task automatic cycle();
        logic [31:0] a, wd, b, res;
        a   = pick(ForwardA_E, RD1_E);
        wd  = pick(ForwardB_E, RD2_E);
        b   = ALUSrcE ? Imm_Ext_E : wd;
        res = ref_alu(ALUControlE, a, b);
        #1;
        chk("pcsrc", {31'd0, PCSrcE}, {31'd0, BranchE && (res == 0)});
        chk("pctarget", PCTargetE, PCE + Imm_Ext_E);
        @(posedge clk);
        #1;
        chk("alu_m", ALUResultM, res);
        chk("wdata_m", WriteDataM, wd);
        chk("ctrl_m", {29'd0, RegWriteM, MemWriteM, ResultSrcM},
            {29'd0, RegWriteE, MemWriteE, ResultSrcE});
        chk("rd_m", {27'd0, RD_M}, {27'd0, RD_E});
        chk("pc4_m", PCPlus4M, PCPlus4E);
        m_alu_prev = res;
    endtask

    task automatic clear_inputs();
        {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE} = '0;
        ALUControlE = 0; RD1_E = 0; RD2_E = 0; Imm_Ext_E = 0; RD_E = 0;
        PCE = 0; PCPlus4E = 0; ResultW = 0; ForwardA_E = 0; ForwardB_E = 0;
    endtask

    task automatic randomize_inputs();
        {RegWriteE, ALUSrcE, MemWriteE, ResultSrcE, BranchE} = 5'($urandom);
        ALUControlE = 3'($urandom);
        RD1_E = $urandom; RD2_E = $urandom; Imm_Ext_E = $urandom;
        RD_E = 5'($urandom); PCE = $urandom; PCPlus4E = $urandom; ResultW = $urandom;
        ForwardA_E = 2'($urandom); ForwardB_E = 2'($urandom);
        if ($urandom_range(0, 3) == 0) begin
            RD2_E = RD1_E; ALUSrcE = 0; ForwardA_E = 0; ForwardB_E = 0; ALUControlE = 3'd1;
        end
        if ($urandom_range(0, 7) == 0) Imm_Ext_E = $urandom_range(0, 40);
    endtask

    initial begin
        // reset held with non-zero inputs
        randomize_inputs();
        RegWriteE = 1; MemWriteE = 1; ResultSrcE = 1; RD_E = 5'd7; PCPlus4E = 32'h44;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_alu", ALUResultM, 0);
        chk("rst_wdata", WriteDataM, 0);
        chk("rst_ctrl", {29'd0, RegWriteM, MemWriteM, ResultSrcM}, 0);
        chk("rst_rd", {27'd0, RD_M}, 0);
        chk("rst_pc4", PCPlus4M, 0);
        m_alu_prev = 0;
        rst = 1;
        cycle();

        // add immediate
        clear_inputs();
        RD1_E = 5; Imm_Ext_E = 7; ALUSrcE = 1; RegWriteE = 1; RD_E = 3;
        cycle();
        chk("add_imm", ALUResultM, 32'd12);

        // branch taken / not taken
        clear_inputs();
        RD1_E = 32'h10; RD2_E = 32'h10; ALUControlE = 3'd1; BranchE = 1;
        PCE = 32'h40; Imm_Ext_E = 32'hFFFF_FFF8;
        #1;
        chk("br_taken", {31'd0, PCSrcE}, 1);
        chk("br_target", PCTargetE, 32'h38);
        RD2_E = 32'h11;
        #1;
        chk("br_not_taken", {31'd0, PCSrcE}, 0);
        cycle();

        // forwarding from M and W
        clear_inputs();
        RD1_E = 32'h20; ALUSrcE = 1; Imm_Ext_E = 0;
        cycle();
        clear_inputs();
        ForwardA_E = 2'b10; ForwardB_E = 2'b01; ResultW = 32'h3;
        cycle();
        chk("fwd_sum", ALUResultM, 32'h23);

        // store data is forwarded value
        clear_inputs();
        MemWriteE = 1; ALUSrcE = 1; ForwardB_E = 2'b01; ResultW = 32'hDEAD_BEEF;
        RD2_E = 32'h1234;
        cycle();
        chk("store_data", WriteDataM, 32'hDEAD_BEEF);

        // edge ops
        clear_inputs();
        RD1_E = 32'h8000_0000; RD2_E = 1; ALUControlE = 3'd5;
        cycle();
        chk("slt_neg", ALUResultM, 1);
        clear_inputs();
        RD1_E = 3; RD2_E = 33; ALUControlE = 3'd6;
        cycle();
        chk("sll_33", ALUResultM, 6);
        clear_inputs();
        RD1_E = 32'hFFFF_FFFF; Imm_Ext_E = 1; ALUSrcE = 1; BranchE = 1;
        #1;
        chk("wrap_zero", {31'd0, PCSrcE}, 1);
        cycle();
        chk("wrap_add", ALUResultM, 0);

        // randomized run with occasional asynchronous reset
        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            if (i % 97 == 50) begin
                rst = 0;
                #1;
                chk("async_rst_alu", ALUResultM, 0);
                chk("async_rst_pc4", PCPlus4M, 0);
                chk("rst_pctarget", PCTargetE, PCE + Imm_Ext_E);
                m_alu_prev = 0;
                #1;
                rst = 1;
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
